apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB4 initiator: converts a single-outstanding valid/ready request/response port from a CPU-side interconnect into APB setup/access transfers. It drives responders such as the SDRAM APB front end and peripheral APB slaves, returning read data and error status. A programmable access timeout guarantees forward progress when a responder never asserts `pready`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum ACCESS-phase cycles before abort; 0 disables timeout.
- `TIMEOUT_DATA`, 32'h0000_0000: `resp_rdata` value returned on a timed-out transfer.

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when high with `req_valid`
- `req_addr`  in  32  byte address
- `req_write`  in  1  1 = write, 0 = read
- `req_wdata`  in  32  write data
- `req_wstrb`  in  4  write byte strobes
- `req_prot`  in  3  APB protection attributes
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  response consumed when high with `resp_valid`
- `resp_rdata`  out  32  read data (0 for writes)
- `resp_err`  out  1  `pslverr` or timeout
- `out_paddr`  out  32  APB address
- `out_psel`  out  1  APB select
- `out_penable`  out  1  APB enable
- `out_pprot`  out  3  APB protection
- `out_pwrite`  out  1  APB direction
- `out_pwdata`  out  32  APB write data
- `out_pstrb`  out  4  APB strobes
- `out_pready`  in  1  responder ready
- `out_prdata`  in  32  responder read data
- `out_pslverr`  in  1  responder error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready`=1; on `req_valid` capture addr/write/wdata/wstrb/prot into registers -> SETUP.
- SETUP (exactly one cycle): `psel`=1, `penable`=0 -> ACCESS.
- ACCESS: `psel`=1, `penable`=1; wait counter increments each cycle `pready`=0.
  - `pready`=1: latch `resp_rdata` = `prdata` (read) or 0 (write), `resp_err` = `pslverr` -> RESP.
  - Counter = `TIMEOUT_CYCLES`-1 and `pready`=0 (and `TIMEOUT_CYCLES`≠0): abort; `resp_rdata` = `TIMEOUT_DATA`, `resp_err`=1 -> RESP.
  - `pready` in the same cycle as timeout expiry: `pready` wins, normal completion.
- RESP: `psel`=`penable`=0, `resp_valid`=1 held with stable data until `resp_ready`; then -> IDLE.
- `req_ready`=0 in SETUP/ACCESS/RESP; one transfer outstanding at most.
- APB fields `paddr/pwrite/pwdata/pstrb/pprot` driven from capture registers, constant SETUP through ACCESS end; `pstrb` forced 4'b0 for reads.
- Wait counter: width clog2(`TIMEOUT_CYCLES`+1), minimum 1 bit; cleared on SETUP entry; saturates, never wraps.
- `out_prdata`/`out_pslverr` sampled only in the `pready` cycle; ignored in all other states.

## Timing
- Reset: state IDLE; `psel`, `penable`, `resp_valid`, `resp_err`=0; `paddr`, `pwdata`, `pstrb`, `pprot`, `pwrite`, `resp_rdata`=0; counter 0. `req_ready`=1 first cycle after reset deasserts.
- Reset asserted mid-transfer: next edge IDLE, `psel`/`penable` drop immediately, pending response discarded.
- Accept at edge N -> SETUP cycle N+1 -> ACCESS cycle N+2; zero-wait `pready` at N+2 -> `resp_valid` at N+3.
- k wait states: `resp_valid` at N+3+k.
- Timeout: `psel` held exactly `TIMEOUT_CYCLES` ACCESS cycles, then `resp_valid` next cycle.
- `resp_ready` high on first `resp_valid` cycle: IDLE next cycle; next accept possible there. Minimum request-to-request period 4 cycles.
- All outputs registered or decoded from state only; no combinational path from `out_pready` or `resp_ready` to any output.

## Test plan
- Write 0x8000_0010 <- 0xA5A5_5A5A, wstrb 4'b0110, zero wait -> SETUP with psel=1/penable=0 then ACCESS psel=1/penable=1, pstrb=0110; resp_valid 3 cycles after accept, resp_rdata=0, resp_err=0.
- Read 0x8000_0020, `pready` after 3 wait states, prdata=0x1234_5678 -> resp_valid at accept+6, resp_rdata=0x1234_5678, pstrb=0 throughout, paddr stable all 4 ACCESS cycles.
- Read with `pslverr`=1 on `pready` cycle -> resp_err=1, resp_rdata=prdata captured.
- TIMEOUT_CYCLES=4, `pready` never asserted -> psel high 1+4 cycles, then dropped; resp_err=1, resp_rdata=TIMEOUT_DATA; `pready`=1 exactly on 4th ACCESS cycle -> normal completion, resp_err=0.
- `resp_ready` held low 5 cycles -> resp_valid/rdata/err stable, req_ready=0, psel=0; back-to-back requests with resp_ready=1 -> accepts every 4 cycles.
- Reset asserted during ACCESS of a write -> psel/penable=0 next cycle, resp_valid never asserts, req_ready=1 after reset release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// APB4 initiator: accepts one request at a time from a valid/ready port,
// runs it as an APB setup/access transfer and returns read data and error
// status on a valid/ready response port. An optional access-phase timeout
// aborts transfers whose responder never raises pready.

module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,

  // CPU-side request port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_prot,

  // CPU-side response port
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,

  // APB initiator port
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  // Wait counter is wide enough to hold TIMEOUT_CYCLES; at least one bit
  // so the design still elaborates when the timeout is disabled.
  localparam int unsigned CW         = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = TIMEOUT_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_count;
  logic          accept;
  logic          complete;
  logic          timeout_hit;

  // Handshake and completion qualifiers shared by the FSM and datapath
  always_comb begin
    accept      = (state == IDLE) && req_valid;
    complete    = (state == ACCESS) && out_pready;
    timeout_hit = TIMEOUT_EN && (state == ACCESS) && !out_pready &&
                  (wait_count == CNT_LAST);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; pready has priority over a simultaneous timeout
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = SETUP;
        end
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (out_pready || timeout_hit) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Handshake and APB phase outputs decoded purely from the state register
  always_comb begin
    req_ready   = 1'b0;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      SETUP: begin
        out_psel = 1'b1;
      end
      ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Capture the request fields on accept; they drive the APB bus unchanged
  // for the whole transfer. Read transfers always carry a zero strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_paddr  <= '0;
      out_pwrite <= 1'b0;
      out_pwdata <= '0;
      out_pstrb  <= '0;
      out_pprot  <= '0;
    end else if (accept) begin
      out_paddr  <= req_addr;
      out_pwrite <= req_write;
      out_pwdata <= req_wdata;
      out_pstrb  <= req_write ? req_wstrb : 4'b0000;
      out_pprot  <= req_prot;
    end
  end

  // Access-phase wait counter: cleared when a transfer starts, counts
  // cycles without pready, and saturates instead of wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_count <= '0;
    end else if (accept) begin
      wait_count <= '0;
    end else if ((state == ACCESS) && !out_pready && (wait_count != CNT_MAX)) begin
      wait_count <= wait_count + 1'b1;
    end
  end

  // Response latch: responder data only on the pready cycle, otherwise the
  // timeout pattern; held stable through RESP until consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (complete) begin
      resp_rdata <= out_pwrite ? 32'h0000_0000 : out_prdata;
      resp_err   <= out_pslverr;
    end else if (timeout_hit) begin
      resp_rdata <= TIMEOUT_DATA;
      resp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed self-checking bench for apb_master_bridge. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.

module tb_apb_master_bridge;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam logic [31:0] TB_TO_DATA = 32'hDEAD_BEEF;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  int errors = 0;
  int checks = 0;

  apb_master_bridge #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .TIMEOUT_DATA  (TB_TO_DATA)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_prot   (req_prot),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .out_paddr  (out_paddr),
    .out_psel   (out_psel),
    .out_penable(out_penable),
    .out_pprot  (out_pprot),
    .out_pwrite (out_pwrite),
    .out_pwdata (out_pwdata),
    .out_pstrb  (out_pstrb),
    .out_pready (out_pready),
    .out_prdata (out_prdata),
    .out_pslverr(out_pslverr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_write  = 1'b0;
    req_wdata  = 32'h0;
    req_wstrb  = 4'h0;
    req_prot   = 3'h0;
    resp_ready = 1'b0;
    out_pready = 1'b0;
    out_prdata = 32'h0;
    out_pslverr = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (out_psel !== 1'b0 || out_penable !== 1'b0) begin errors++; $display("[TB] FAIL reset_psel_penable: got %b%b expected 00", out_psel, out_penable); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp: got valid=%b err=%b expected 0 0", resp_valid, resp_err); end
    checks++; if (out_paddr !== 32'h0 || out_pwdata !== 32'h0 || resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got paddr=%h pwdata=%h rdata=%h expected zeros", out_paddr, out_pwdata, resp_rdata); end
    checks++; if (out_pstrb !== 4'h0 || out_pprot !== 3'h0 || out_pwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl: got pstrb=%b pprot=%b pwrite=%b expected zeros", out_pstrb, out_pprot, out_pwrite); end
  endtask

  task automatic test_write_zero_wait;
    // IDLE: present the write
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_idle_ready: got %b expected 1", req_ready); end
    req_valid = 1'b1;
    req_addr  = 32'h8000_0010;
    req_write = 1'b1;
    req_wdata = 32'hA5A5_5A5A;
    req_wstrb = 4'b0110;
    req_prot  = 3'b010;
    @(negedge clock);
    // SETUP
    req_valid = 1'b0;
    checks++; if (out_psel !== 1'b1 || out_penable !== 1'b0) begin errors++; $display("[TB] FAIL wr_setup_phase: got psel=%b penable=%b expected 1 0", out_psel, out_penable); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_setup_ready: got %b expected 0", req_ready); end
    checks++; if (out_paddr !== 32'h8000_0010 || out_pwdata !== 32'hA5A5_5A5A || out_pwrite !== 1'b1 || out_pprot !== 3'b010) begin errors++; $display("[TB] FAIL wr_setup_fields: got paddr=%h pwdata=%h pwrite=%b pprot=%b expected 80000010 a5a55a5a 1 010", out_paddr, out_pwdata, out_pwrite, out_pprot); end
    @(negedge clock);
    // ACCESS, zero wait
    checks++; if (out_psel !== 1'b1 || out_penable !== 1'b1) begin errors++; $display("[TB] FAIL wr_access_phase: got psel=%b penable=%b expected 1 1", out_psel, out_penable); end
    checks++; if (out_pstrb !== 4'b0110) begin errors++; $display("[TB] FAIL wr_access_pstrb: got %b expected 0110", out_pstrb); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_access_resp_valid: got %b expected 0", resp_valid); end
    out_pready = 1'b1;
    out_prdata = 32'h7777_7777;
    @(negedge clock);
    // RESP, three edges after accept
    out_pready = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL wr_resp_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp_data: got rdata=%h err=%b expected 00000000 0", resp_rdata, resp_err); end
    checks++; if (out_psel !== 1'b0 || out_penable !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp_bus_idle: got psel=%b penable=%b expected 0 0", out_psel, out_penable); end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_back_idle: got resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_read_wait_states;
    req_valid   = 1'b1;
    req_addr    = 32'h8000_0020;
    req_write   = 1'b0;
    req_wdata   = 32'hFFFF_FFFF;
    req_wstrb   = 4'b1111;
    req_prot    = 3'b001;
    out_pready  = 1'b0;
    out_pslverr = 1'b1;
    out_prdata  = 32'hFFFF_FFFF;
    @(negedge clock);
    // SETUP
    req_valid = 1'b0;
    checks++; if (out_psel !== 1'b1 || out_penable !== 1'b0 || out_pstrb !== 4'b0000 || out_pwrite !== 1'b0) begin errors++; $display("[TB] FAIL rd_setup: got psel=%b penable=%b pstrb=%b pwrite=%b expected 1 0 0000 0", out_psel, out_penable, out_pstrb, out_pwrite); end
    // Four ACCESS cycles; pready lands on the last, which is also the timeout cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if (out_psel !== 1'b1 || out_penable !== 1'b1) begin errors++; $display("[TB] FAIL rd_access_phase[%0d]: got psel=%b penable=%b expected 1 1", i, out_psel, out_penable); end
      checks++; if (out_paddr !== 32'h8000_0020 || out_pstrb !== 4'b0000) begin errors++; $display("[TB] FAIL rd_access_fields[%0d]: got paddr=%h pstrb=%b expected 80000020 0000", i, out_paddr, out_pstrb); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_access_resp_valid[%0d]: got %b expected 0", i, resp_valid); end
      if (i == 3) begin
        out_pready  = 1'b1;
        out_pslverr = 1'b0;
        out_prdata  = 32'h1234_5678;
      end
    end
    @(negedge clock);
    // RESP at accept + 6
    out_pready  = 1'b0;
    out_prdata  = 32'hFFFF_FFFF;
    out_pslverr = 1'b1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_resp_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL rd_resp_data: got rdata=%h err=%b expected 12345678 0", resp_rdata, resp_err); end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready  = 1'b0;
    out_pslverr = 1'b0;
  endtask

  task automatic test_read_slverr;
    req_valid   = 1'b1;
    req_addr    = 32'h4000_0100;
    req_write   = 1'b0;
    req_prot    = 3'b000;
    out_pready  = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    // ACCESS: zero-wait error response
    out_pready  = 1'b1;
    out_pslverr = 1'b1;
    out_prdata  = 32'hCAFE_F00D;
    @(negedge clock);
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    out_prdata  = 32'h0;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("[TB] FAIL err_resp_flag: got valid=%b err=%b expected 1 1", resp_valid, resp_err); end
    checks++; if (resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL err_resp_rdata: got %h expected cafef00d", resp_rdata); end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int psel_cycles;
    bit got_resp;
    psel_cycles = 0;
    got_resp    = 1'b0;
    req_valid   = 1'b1;
    req_addr    = 32'h8000_0030;
    req_write   = 1'b0;
    out_pready  = 1'b0;
    out_prdata  = 32'h5555_AAAA;
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid === 1'b1) begin
        got_resp = 1'b1;
        break;
      end
      if (out_psel === 1'b1) psel_cycles++;
      @(negedge clock);
    end
    checks++; if (got_resp !== 1'b1) begin errors++; $display("[TB] FAIL to_resp_seen: got %b expected 1 within 20 cycles", got_resp); end
    checks++; if (psel_cycles != 5) begin errors++; $display("[TB] FAIL to_psel_cycles: got %0d expected 5", psel_cycles); end
    checks++; if (resp_err !== 1'b1 || resp_rdata !== TB_TO_DATA) begin errors++; $display("[TB] FAIL to_resp_data: got err=%b rdata=%h expected 1 deadbeef", resp_err, resp_rdata); end
    checks++; if (out_psel !== 1'b0) begin errors++; $display("[TB] FAIL to_psel_dropped: got %b expected 0", out_psel); end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_resp_backpressure;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0040;
    req_write  = 1'b0;
    out_pready = 1'b1;
    out_prdata = 32'h0BAD_F00D;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    // RESP; disturb the responder inputs while the response waits
    out_prdata  = 32'h1111_1111;
    out_pslverr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_F00D || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b expected 1 0badf00d 0", i, resp_valid, resp_rdata, resp_err); end
      checks++; if (req_ready !== 1'b0 || out_psel !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle_bus[%0d]: got req_ready=%b psel=%b expected 0 0", i, req_ready, out_psel); end
      req_valid = 1'b1;
      @(negedge clock);
    end
    req_valid   = 1'b0;
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    resp_ready  = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got valid=%b req_ready=%b expected 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    int accepts;
    int resps;
    int last_accept;
    accepts     = 0;
    resps       = 0;
    last_accept = -1;
    req_valid   = 1'b1;
    req_addr    = 32'h8000_0050;
    req_write   = 1'b1;
    req_wdata   = 32'h0F0F_0F0F;
    req_wstrb   = 4'b1111;
    resp_ready  = 1'b1;
    out_pready  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready === 1'b1) begin
        if (last_accept >= 0) begin
          checks++; if (i - last_accept != 4) begin errors++; $display("[TB] FAIL b2b_period: got %0d expected 4", i - last_accept); end
        end
        accepts++;
        last_accept = i;
      end
      if (resp_valid === 1'b1) resps++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    checks++; if (accepts != 3) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d expected 3", accepts); end
    checks++; if (resps != 3) begin errors++; $display("[TB] FAIL b2b_resps: got %0d expected 3", resps); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_final_ready: got %b expected 1", req_ready); end
    @(negedge clock);
    resp_ready = 1'b0;
    out_pready = 1'b0;
  endtask

  task automatic test_reset_mid_transfer;
    bit saw_resp;
    saw_resp   = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0060;
    req_write  = 1'b1;
    req_wdata  = 32'h1357_9BDF;
    req_wstrb  = 4'b0011;
    out_pready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (out_penable !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_access: got penable=%b expected 1", out_penable); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (out_psel !== 1'b0 || out_penable !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_bus_drop: got psel=%b penable=%b expected 0 0", out_psel, out_penable); end
    checks++; if (out_paddr !== 32'h0 || out_pstrb !== 4'h0) begin errors++; $display("[TB] FAIL rst_mid_fields: got paddr=%h pstrb=%b expected 00000000 0000", out_paddr, out_pstrb); end
    out_pready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid === 1'b1) saw_resp = 1'b1;
      @(negedge clock);
    end
    out_pready = 1'b0;
    checks++; if (saw_resp !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_no_resp: got %b expected 0", saw_resp); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", req_ready); end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] apb_master_bridge directed test start");
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_read_slverr();
    test_timeout();
    test_resp_backpressure();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
